pc_fetch_unit: RTL and testbench

Instruction-fetch PC sequencer for the five-stage pipeline. Owns the program counter, drives the instruction-memory address, and consumes the redirect produced in the register-decode stage by the branch resolver (`br_taken`, `pc_br`). It applies one architectural branch delay slot, honours hazard-unit stalls and counts committed fetches.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/add.sv | 10 +
 rtl/pc_fetch_unit.sv | 50 +++++
 tb/tb_pc_fetch_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, opcode encodings and fetch state enum
package cpu_pkg;
  localparam int PC_W = 64;
  localparam logic [63:0] PC_INIT = 64'h0;
  typedef enum logic [3:0] {
    ADDI = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    LD   = 4'd3,
    ST   = 4'd4,
    BEQ  = 4'd5,
    BNE  = 4'd6,
    JMP  = 4'd7,
    NOP  = 4'd8,
    INV  = 4'd15
  } opcode_t;
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fetch_state_t;
endpackage

// File: rtl/add.sv
// add: W-bit modulo adder
module add #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer with stall, decode-stage redirect and fetch counter; DELAY_SLOT_EN keeps the instruction behind a taken branch
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  pc_br,
  output logic [PC_W-1:0]  imem_addr,
  output logic [PC_W-1:0]  pc_if,
  output logic             fetch_valid,
  output logic             flush_id,
  output logic [CNT_W-1:0] fetch_cnt
);
  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            run;
  add #(.W(PC_W)) u_add (
    .a(pc_q),
    .b(PC_W'(4)),
    .y(pc_inc)
  );
  assign run         = state_q == RUN;
  assign fetch_valid = run && !reset;
`ifdef DELAY_SLOT_EN
  assign flush_id = 1'b0;
`else
  assign flush_id = br_taken && !stall && run;
`endif
  assign imem_addr = pc_q;
  assign pc_if     = pc_q;
  assign fetch_cnt = cnt_q;
  // next state: reset wins, stall or BOOT holds the PC, then redirect, then PC+4
  always_comb begin
    state_d = reset ? BOOT : RUN;
    pc_d    = reset ? PC_W'(PC_INIT) : (!run || stall) ? pc_q : br_taken ? pc_br : pc_inc;
    cnt_d   = reset ? '0 : cnt_q + CNT_W'(fetch_valid && !stall && !flush_id);
  end
  // state, PC and fetch counter registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    cnt_q   <= cnt_d;
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for pc_fetch_unit, plus a narrow-counter instance for wrap
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] pc_br = '0;
  logic [63:0] imem_addr, pc_if, imem_addr_s, pc_if_s;
  logic        fetch_valid, flush_id, fetch_valid_s, flush_id_s;
  logic [31:0] fetch_cnt;
  logic [2:0]  fetch_cnt_s;
  int          n_checks = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  pc_fetch_unit #(.PC_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .pc_br(pc_br),
    .imem_addr(imem_addr), .pc_if(pc_if), .fetch_valid(fetch_valid),
    .flush_id(flush_id), .fetch_cnt(fetch_cnt)
  );
  pc_fetch_unit #(.PC_W(64), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .pc_br(pc_br),
    .imem_addr(imem_addr_s), .pc_if(pc_if_s), .fetch_valid(fetch_valid_s),
    .flush_id(flush_id_s), .fetch_cnt(fetch_cnt_s)
  );
  typedef struct {
    logic        rst, stl, br;
    logic [63:0] pcbr, addr;
    logic        v, f;
    logic [31:0] c_sq, c_ds;
  } vec_t;
  typedef struct {
    int          row;
    logic [63:0] addr;
    logic        v, f;
    logic [31:0] c;
  } exp_t;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
  vec_t tab[23] = '{
    '{1, 0, 0, 64'h0,   64'h0,    0, 0, 0, 0},
    '{1, 0, 0, 64'h0,   64'h0,    0, 0, 0, 0},
    '{1, 0, 0, 64'h0,   64'h0,    0, 0, 0, 0},
    '{0, 0, 0, 64'h0,   64'h0,    0, 0, 0, 0},
    '{0, 0, 0, 64'h0,   64'h0,    1, 0, 0, 0},
    '{0, 0, 0, 64'h0,   64'h4,    1, 0, 1, 1},
    '{0, 0, 0, 64'h0,   64'h8,    1, 0, 2, 2},
    '{0, 0, 0, 64'h0,   64'hc,    1, 0, 3, 3},
    '{0, 0, 1, 64'h100, 64'h10,   1, 1, 4, 4},
    '{0, 0, 0, 64'h0,   64'h100,  1, 0, 4, 5},
    '{0, 0, 1, 64'h20,  64'h104,  1, 1, 5, 6},
    '{0, 1, 1, 64'h200, 64'h20,   1, 0, 5, 7},
    '{0, 1, 1, 64'h200, 64'h20,   1, 0, 5, 7},
    '{0, 0, 0, 64'h0,   64'h20,   1, 0, 5, 7},
    '{0, 0, 1, 64'h40,  64'h24,   1, 1, 6, 8},
    '{0, 0, 1, 64'h80,  64'h40,   1, 1, 6, 9},
    '{0, 0, 1, TOP,     64'h80,   1, 1, 6, 10},
    '{0, 0, 0, 64'h0,   TOP,      1, 0, 6, 11},
    '{0, 0, 0, 64'h0,   64'h0,    1, 0, 7, 12},
    '{1, 0, 1, 64'h300, 64'h4,    0, 1, 8, 13},
    '{0, 0, 1, 64'h300, 64'h0,    0, 0, 0, 0},
    '{0, 0, 0, 64'h0,   64'h0,    1, 0, 0, 0},
    '{0, 0, 0, 64'h0,   64'h4,    1, 0, 1, 1}
  };
  exp_t sb[$];
  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, req);
    end
  endtask
  initial begin
    exp_t e;
    @(posedge clk);
    foreach (tab[i]) begin
      #2;
      reset    = tab[i].rst;
      stall    = tab[i].stl;
      br_taken = tab[i].br;
      pc_br    = tab[i].pcbr;
      e.row  = i;
      e.addr = tab[i].addr;
      e.v    = tab[i].v;
`ifdef DELAY_SLOT_EN
      e.f = 1'b0;
      e.c = tab[i].c_ds;
`else
      e.f = tab[i].f;
      e.c = tab[i].c_sq;
`endif
      sb.push_back(e);
      @(posedge clk);
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("imem_addr", e.row, imem_addr, e.addr);
      chk("pc_if", e.row, pc_if, e.addr);
      chk("fetch_valid", e.row, 64'(fetch_valid), 64'(e.v));
      chk("flush_id", e.row, 64'(flush_id), 64'(e.f));
      chk("fetch_cnt", e.row, 64'(fetch_cnt), 64'(e.c));
      chk("fetch_cnt_w3", e.row, 64'(fetch_cnt_s), 64'(e.c % 8));
    end
  end
endmodule
